// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings,
// flag bit positions inside the flags bus and the handshake FSM states.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_INC = 4'b0010;
  localparam logic [3:0] OP_DEC = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_NOT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;

  // flags = {err, ovf, neg, zero, carry}
  localparam int FLAG_CARRY = 0;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_NEG   = 2;
  localparam int FLAG_OVF   = 3;
  localparam int FLAG_ERR   = 4;
  localparam int FLAG_W     = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier, one multiplier bit per cycle.
// start_i latches the operands; done_o is high during the last iteration
// and product_o then already carries the final product, so the caller can
// register it on the same edge that completes the last step.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] accHi_q;
  logic [WIDTH-1:0] accLo_q;
  logic [WIDTH-1:0] mcand_q;
  logic [CW-1:0]    count_q;
  logic             busy_q;
  logic [WIDTH:0]   stepSum;

  // Low half starts as the multiplier and is shifted out as the product fills in.
  assign stepSum   = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, mcand_q} : '0);
  assign product_o = {stepSum, accLo_q[WIDTH-1:1]};
  assign done_o    = busy_q && (count_q == CW'(WIDTH - 1));
  assign busy_o    = busy_q;

  // Iteration register: load on start, then add-and-shift until the last bit is consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      count_q <= '0;
      accHi_q <= '0;
      accLo_q <= '0;
      mcand_q <= '0;
    end else if (start_i) begin
      busy_q  <= 1'b1;
      count_q <= '0;
      accHi_q <= '0;
      accLo_q <= b_i;
      mcand_q <= a_i;
    end else if (busy_q) begin
      {accHi_q, accLo_q} <= product_o;
      count_q            <= count_q + 1'b1;
      if (done_o) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with valid/ready handshakes on both sides.
// Single-cycle ops complete one edge after acceptance; when the
// ALU_MUL_EN macro is defined, MUL runs on the shift-add multiplier
// for WIDTH cycles while the input side is stalled. Without the macro
// MUL decodes as an illegal opcode and y_hi is tied to zero.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic [4:0]       flags
);
  localparam int MSB = WIDTH - 1;

  state_t           state_q, state_d;
  logic             outValid_q;
  logic [WIDTH-1:0] y_q;
  logic [4:0]       flags_q;

  logic             accept, isMul, mulStart, mulDone, mulBusy;
  logic [WIDTH-1:0] addOperand, subOperand;
  logic             addCarry, addOvf, subOvf;
  logic [WIDTH:0]   sumFull, diffFull;
  logic [WIDTH-1:0] aluY;
  logic [4:0]       aluFlags;

  // INC/DEC reuse the adder/subtractor with a constant one; carry_in only feeds ADD.
  assign addOperand = (op == OP_INC) ? WIDTH'(1) : b;
  assign subOperand = (op == OP_DEC) ? WIDTH'(1) : b;
  assign addCarry   = (op == OP_ADD) && carry_in;
  assign sumFull    = {1'b0, a} + {1'b0, addOperand} + {{WIDTH{1'b0}}, addCarry};
  assign diffFull   = {1'b0, a} - {1'b0, subOperand};
  assign addOvf     = (a[MSB] == addOperand[MSB]) && (sumFull[MSB] != a[MSB]);
  assign subOvf     = (a[MSB] != subOperand[MSB]) && (diffFull[MSB] != a[MSB]);

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] mulProduct;
  logic [4:0]         mulFlags;
  logic [WIDTH-1:0]   yHi_q;

  assign isMul = (op == OP_MUL);
  assign y_hi  = yHi_q;

  alu_mul_seq #(.WIDTH(WIDTH)) uMul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (mulStart),
    .a_i       (a),
    .b_i       (b),
    .busy_o    (mulBusy),
    .done_o    (mulDone),
    .product_o (mulProduct)
  );

  // Product flags: overflow means the result does not fit in the low half.
  always_comb begin
    mulFlags             = '0;
    mulFlags[FLAG_OVF]   = |mulProduct[2*WIDTH-1:WIDTH];
    mulFlags[FLAG_ZERO]  = (mulProduct == '0);
    mulFlags[FLAG_NEG]   = mulProduct[2*WIDTH-1];
  end
`else
  assign isMul   = 1'b0;
  assign mulDone = 1'b0;
  assign mulBusy = 1'b0;
  assign y_hi    = '0;
`endif

  // Single-cycle datapath and flags; anything not decoded here reports err with a zero result.
  always_comb begin
    aluY     = '0;
    aluFlags = '0;
    case (op)
      OP_ADD, OP_INC: begin
        aluY                 = sumFull[MSB:0];
        aluFlags[FLAG_CARRY] = sumFull[WIDTH];
        aluFlags[FLAG_OVF]   = addOvf;
      end
      OP_SUB, OP_DEC: begin
        aluY                 = diffFull[MSB:0];
        aluFlags[FLAG_CARRY] = diffFull[WIDTH];
        aluFlags[FLAG_OVF]   = subOvf;
      end
      OP_AND:  aluY = a & b;
      OP_OR:   aluY = a | b;
      OP_XOR:  aluY = a ^ b;
      OP_NOT:  aluY = ~a;
      default: aluFlags[FLAG_ERR] = 1'b1;
    endcase
    if (!aluFlags[FLAG_ERR]) begin
      aluFlags[FLAG_ZERO] = (aluY == '0);
      aluFlags[FLAG_NEG]  = aluY[MSB];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: stay BUSY only while the multiplier is still iterating.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mulStart) state_d = ST_BUSY;
      ST_BUSY: if (mulDone || !mulBusy) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: accept only when idle and the output slot is empty or draining this edge.
  always_comb begin
    in_ready = rst_n && (state_q == ST_IDLE) && (!outValid_q || out_ready);
    accept   = in_valid && in_ready;
    mulStart = accept && isMul;
  end

  // Output register: load on completion, otherwise hold until the consumer takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outValid_q <= 1'b0;
      y_q        <= '0;
      flags_q    <= '0;
`ifdef ALU_MUL_EN
      yHi_q      <= '0;
`endif
    end else if (accept && !isMul) begin
      outValid_q <= 1'b1;
      y_q        <= aluY;
      flags_q    <= aluFlags;
`ifdef ALU_MUL_EN
      yHi_q      <= '0;
    end else if (mulDone) begin
      outValid_q <= 1'b1;
      y_q        <= mulProduct[WIDTH-1:0];
      yHi_q      <= mulProduct[2*WIDTH-1:WIDTH];
      flags_q    <= mulFlags;
`endif
    end else if (out_ready) begin
      outValid_q <= 1'b0;
    end
  end

  assign out_valid = outValid_q;
  assign y         = y_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (WIDTH=8): directed vectors, backpressure,
// back-to-back throughput, reset abort and a randomized scoreboard run,
// all checked against an arithmetic reference model.
// Honours ALU_MUL_EN the same way as the design.
module tb_alu_seq;

  localparam int W = 8;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] y;
    logic [W-1:0] yHi;
    logic [4:0]   flags;
  } expect_t;

  logic         clk = 1'b0;
  logic         rst_n, inValid, inReady, carryIn, outValid, outReady;
  logic [3:0]   op;
  logic [W-1:0] a, b, y, yHi;
  logic [4:0]   flags;

  int      checkCount = 0;
  int      errorCount = 0;
  expect_t sbQueue[$];

  // Free-running clock.
  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .op        (op),
    .a         (a),
    .b         (b),
    .carry_in  (carryIn),
    .out_valid (outValid),
    .out_ready (outReady),
    .y         (y),
    .y_hi      (yHi),
    .flags     (flags)
  );

  // Reference model: plain integer arithmetic on the operation's definition.
  function automatic expect_t model(input logic [3:0] opc, input logic [W-1:0] x,
                                    input logic [W-1:0] z, input logic cin);
    expect_t r;
    int ux, uz, sx, sz, full, sres, prod;
    bit arith, isAdd, err, ovf, carry;
    r = '0; full = 0; sres = 0; prod = 0;
    arith = 1'b1; isAdd = 1'b1; err = 1'b0; ovf = 1'b0; carry = 1'b0;
    ux = int'(x); uz = int'(z);
    sx = $signed(x); sz = $signed(z);
    case (opc)
      4'd0: begin full = ux + uz + int'(cin); sres = sx + sz + int'(cin); end
      4'd1: begin full = ux - uz; sres = sx - sz; isAdd = 1'b0; end
      4'd2: begin full = ux + 1; sres = sx + 1; end
      4'd3: begin full = ux - 1; sres = sx - 1; isAdd = 1'b0; end
      4'd4: begin arith = 1'b0; r.y = x & z; end
      4'd5: begin arith = 1'b0; r.y = x | z; end
      4'd6: begin arith = 1'b0; r.y = x ^ z; end
      4'd7: begin arith = 1'b0; r.y = ~x; end
      4'd8: begin
        arith = 1'b0;
        if (MUL_EN) begin
          prod  = ux * uz;
          r.y   = prod[W-1:0];
          r.yHi = prod[2*W-1:W];
          ovf   = (r.yHi != 0);
        end else begin
          err = 1'b1;
        end
      end
      default: begin arith = 1'b0; err = 1'b1; end
    endcase
    if (arith) begin
      r.y   = full[W-1:0];
      carry = isAdd ? (full >= (1 << W)) : (full < 0);
      ovf   = (sres > (1 << (W-1)) - 1) || (sres < -(1 << (W-1)));
    end
    if (err) begin
      r = '0;
      r.flags = 5'b10000;
    end else if (opc == 4'd8) begin
      r.flags = {1'b0, ovf, r.yHi[W-1], ({r.yHi, r.y} == 0), 1'b0};
    end else begin
      r.flags = {1'b0, ovf, r.y[W-1], (r.y == 0), carry};
    end
    return r;
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Offer one operation and wait (bounded) for the accepting edge; returns at edge+1.
  task automatic applyStimulus(input logic [3:0] opc, input logic [W-1:0] x,
                               input logic [W-1:0] z, input logic cin);
    bit taken, ready;
    taken = 1'b0;
    op = opc; a = x; b = z; carryIn = cin; inValid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #1;
      ready = inReady;
      @(posedge clk); #1;
      if (ready) begin
        taken = 1'b1;
        break;
      end
    end
    inValid = 1'b0;
    if (!taken) checkOutput("accept timeout", 32'd0, 32'd1);
  endtask

  // One isolated op: check latency, stall, result and drain.
  task automatic directedOp(input string tag, input logic [3:0] opc, input logic [W-1:0] x,
                            input logic [W-1:0] z, input logic cin);
    expect_t e;
    int waitCycles;
    e = model(opc, x, z, cin);
    waitCycles = (MUL_EN && opc == 4'd8) ? W : 0;
    outReady = 1'b0;
    applyStimulus(opc, x, z, cin);
    for (int i = 0; i < waitCycles; i++) begin
      checkOutput({tag, " busy out_valid"}, 32'(outValid), 32'd0);
      checkOutput({tag, " busy in_ready"}, 32'(inReady), 32'd0);
      @(posedge clk); #1;
    end
    checkOutput({tag, " out_valid"}, 32'(outValid), 32'd1);
    checkOutput({tag, " y"}, 32'(y), 32'(e.y));
    checkOutput({tag, " y_hi"}, 32'(yHi), 32'(e.yHi));
    checkOutput({tag, " flags"}, 32'(flags), 32'(e.flags));
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
    checkOutput({tag, " drained"}, 32'(outValid), 32'd0);
  endtask

  initial begin
    expect_t e;
    logic [W-1:0] heldY;
    logic [4:0]   heldFlags;
    int seen;

    rst_n = 1'b0; inValid = 1'b0; outReady = 1'b0;
    op = '0; a = '0; b = '0; carryIn = 1'b0;

    // Reset state.
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("reset in_ready", 32'(inReady), 32'd0);
    checkOutput("reset out_valid", 32'(outValid), 32'd0);
    checkOutput("reset y", 32'(y), 32'd0);
    checkOutput("reset y_hi", 32'(yHi), 32'd0);
    checkOutput("reset flags", 32'(flags), 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("post-reset in_ready", 32'(inReady), 32'd1);
    @(posedge clk); #1;

    // Directed vectors, including the wrap, borrow and overflow corners.
    directedOp("ADD FF+01", 4'd0, 8'hFF, 8'h01, 1'b0);
    directedOp("ADD 7F+00+c", 4'd0, 8'h7F, 8'h00, 1'b1);
    directedOp("SUB 80-01", 4'd1, 8'h80, 8'h01, 1'b0);
    directedOp("SUB 05-09", 4'd1, 8'h05, 8'h09, 1'b1);
    directedOp("INC 7F", 4'd2, 8'h7F, 8'h00, 1'b1);
    directedOp("DEC 00", 4'd3, 8'h00, 8'h55, 1'b0);
    directedOp("AND", 4'd4, 8'hF0, 8'h3C, 1'b0);
    directedOp("OR", 4'd5, 8'h00, 8'h00, 1'b0);
    directedOp("XOR", 4'd6, 8'hA5, 8'hFF, 1'b0);
    directedOp("NOT", 4'd7, 8'h0F, 8'h00, 1'b0);
    directedOp("MUL 0F*11", 4'd8, 8'h0F, 8'h11, 1'b0);
    directedOp("MUL FF*FF", 4'd8, 8'hFF, 8'hFF, 1'b0);
    directedOp("illegal A", 4'hA, 8'h12, 8'h34, 1'b1);

    // Backpressure: result must hold and inputs must be refused.
    e = model(4'd0, 8'h3C, 8'h45, 1'b1);
    applyStimulus(4'd0, 8'h3C, 8'h45, 1'b1);
    heldY = y; heldFlags = flags;
    checkOutput("bp y", 32'(heldY), 32'(e.y));
    for (int i = 0; i < 3; i++) begin
      op = 4'd6; a = 8'hFF; b = 8'h01; inValid = 1'b1;
      #1;
      checkOutput("bp in_ready", 32'(inReady), 32'd0);
      @(posedge clk); #1;
      checkOutput("bp out_valid", 32'(outValid), 32'd1);
      checkOutput("bp y stable", 32'(y), 32'(heldY));
      checkOutput("bp flags stable", 32'(flags), 32'(heldFlags));
    end
    inValid = 1'b0;
    outReady = 1'b1;
    #1;
    checkOutput("bp drain in_ready", 32'(inReady), 32'd1);
    @(posedge clk); #1;
    checkOutput("bp drained", 32'(outValid), 32'd0);

    // Back-to-back single-cycle ops: one result per cycle.
    for (int i = 0; i < 6; i++) begin
      op = 4'($urandom_range(0, 7));
      a = 8'($urandom); b = 8'($urandom); carryIn = 1'($urandom);
      e = model(op, a, b, carryIn);
      inValid = 1'b1;
      #1;
      checkOutput("b2b in_ready", 32'(inReady), 32'd1);
      @(posedge clk); #1;
      checkOutput("b2b out_valid", 32'(outValid), 32'd1);
      checkOutput("b2b result", 32'({y, flags}), 32'({e.y, e.flags}));
    end
    inValid = 1'b0;
    @(posedge clk); #1;
    checkOutput("b2b idle", 32'(outValid), 32'd0);

    // Reset in the middle of a pending operation: nothing must emerge afterwards.
    outReady = 1'b0;
    applyStimulus(MUL_EN ? 4'd8 : 4'd0, 8'hC3, 8'h5A, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort out_valid", 32'(outValid), 32'd0);
    checkOutput("abort in_ready in reset", 32'(inReady), 32'd0);
    rst_n = 1'b1;
    outReady = 1'b1;
    #1;
    checkOutput("abort in_ready", 32'(inReady), 32'd1);
    seen = 0;
    for (int i = 0; i < W + 3; i++) begin
      @(posedge clk); #1;
      if (outValid) seen++;
    end
    checkOutput("abort no result", 32'(seen), 32'd0);

    // Randomized traffic against a result queue.
    for (int cyc = 0; cyc < 400; cyc++) begin
      outReady = ($urandom_range(0, 3) != 0);
      inValid  = 1'($urandom);
      op = 4'($urandom_range(0, 15));
      a = 8'($urandom); b = 8'($urandom); carryIn = 1'($urandom);
      #1;
      if (outValid && outReady) begin
        if (sbQueue.size() == 0) begin
          checkOutput("sb unexpected result", 32'd1, 32'd0);
        end else begin
          e = sbQueue.pop_front();
          checkOutput("sb result", 32'({y, yHi, flags}), 32'({e.y, e.yHi, e.flags}));
        end
      end
      if (inValid && inReady) sbQueue.push_back(model(op, a, b, carryIn));
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    outReady = 1'b1;
    for (int i = 0; i < 40 && sbQueue.size() != 0; i++) begin
      #1;
      if (outValid) begin
        e = sbQueue.pop_front();
        checkOutput("sb drain result", 32'({y, yHi, flags}), 32'({e.y, e.yHi, e.flags}));
      end
      @(posedge clk); #1;
    end
    checkOutput("sb drained", 32'(sbQueue.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
